// File: rtl/pkt256_rr_arbiter.sv
// Round-robin merge of NPORT unstallable 256-bit word sources into one ready/valid stream.
// Each port has a single holding slot; a strobe into a full slot that is not moving is dropped and counted.
module pkt256_rr_arbiter #(
  parameter int NPORT = 4,
  parameter int PW    = (NPORT > 1) ? $clog2(NPORT) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NPORT-1:0]      in_en,
  input  logic [NPORT*256-1:0]  in_data,
  input  logic [NPORT*4-1:0]    in_id,
  input  logic [NPORT*16-1:0]   in_segnum,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [255:0]          out_data,
  output logic [3:0]            out_id,
  output logic [15:0]           out_segnum,
  output logic [PW-1:0]         out_port,
  output logic [NPORT-1:0]      ovf,
  output logic [15:0]           drop_cnt,
  input  logic                  ovf_clr
);

  logic [255:0]     slot_data_r [NPORT];
  logic [3:0]       slot_id_r   [NPORT];
  logic [15:0]      slot_seg_r  [NPORT];
  logic [NPORT-1:0] full_r;
  logic [PW-1:0]    last_grant_r;

  logic             found_s;
  logic             load_s;
  logic [PW-1:0]    grant_s;
  logic [PW-1:0]    idx_s;
  logic [NPORT-1:0] move_s;
  logic [NPORT-1:0] capture_s;
  logic [NPORT-1:0] drop_s;
  logic [3:0]       drop_num_s;
  logic [15:0]      drop_base_s;
  logic [16:0]      drop_sum_s;

  // Round-robin search for the first full slot after the last grant.
  always_comb begin
    found_s = 1'b0;
    grant_s = '0;
    idx_s   = '0;
    for (int i = 1; i <= NPORT; i++) begin
      idx_s = PW'((int'(last_grant_r) + i) % NPORT);
      if (!found_s && full_r[idx_s]) begin
        found_s = 1'b1;
        grant_s = idx_s;
      end else begin
        grant_s = grant_s;
      end
    end
  end

  assign load_s = found_s && (!out_valid || out_ready);

  // Per-port capture/move/drop decisions and the combined drop count.
  always_comb begin
    move_s     = '0;
    capture_s  = '0;
    drop_s     = '0;
    drop_num_s = 4'd0;
    for (int p = 0; p < NPORT; p++) begin
      move_s[p]    = load_s && (grant_s == PW'(p));
      capture_s[p] = in_en[p] && (!full_r[p] || move_s[p]);
      drop_s[p]    = in_en[p] && full_r[p] && !move_s[p];
      drop_num_s   = drop_num_s + {3'b000, drop_s[p]};
    end
    drop_base_s = ovf_clr ? 16'h0000 : drop_cnt;
    drop_sum_s  = {1'b0, drop_base_s} + {13'h0000, drop_num_s};
  end

  // Holding slots: a slot leaving for the output can take a new word in the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_r <= '0;
      for (int p = 0; p < NPORT; p++) begin
        slot_data_r[p] <= 256'd0;
        slot_id_r[p]   <= 4'd0;
        slot_seg_r[p]  <= 16'd0;
      end
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        if (capture_s[p]) begin
          full_r[p]      <= 1'b1;
          slot_data_r[p] <= in_data[p*256 +: 256];
          slot_id_r[p]   <= in_id[p*4 +: 4];
          slot_seg_r[p]  <= in_segnum[p*16 +: 16];
        end else if (move_s[p]) begin
          full_r[p] <= 1'b0;
        end
      end
    end
  end

  // Output stage: holds its word until accepted, reloads back-to-back when a slot is full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_data     <= 256'd0;
      out_id       <= 4'd0;
      out_segnum   <= 16'd0;
      out_port     <= '0;
      last_grant_r <= PW'(NPORT - 1);
    end else if (load_s) begin
      out_valid    <= 1'b1;
      out_data     <= slot_data_r[grant_s];
      out_id       <= slot_id_r[grant_s];
      out_segnum   <= slot_seg_r[grant_s];
      out_port     <= grant_s;
      last_grant_r <= grant_s;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Overflow flags and saturating drop counter; drops in a clearing cycle survive the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf      <= '0;
      drop_cnt <= 16'd0;
    end else begin
      ovf      <= (ovf_clr ? {NPORT{1'b0}} : ovf) | drop_s;
      drop_cnt <= drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
    end
  end

endmodule
